// File: rtl/encoder_display_scanner_if.sv
// Display-scanner bus: value/update handshake from the position source plus the
// multiplexed seven-segment pins.
interface encoder_display_scanner_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DATA_W-1:0]     value;
  logic                  update_req;
  logic                  update_ack;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [IDX_W-1:0]      digit_idx;

  modport master (
    output value,
    output update_req,
    input  update_ack,
    input  seg,
    input  digit_en,
    input  digit_idx
  );

  modport slave (
    input  value,
    input  update_req,
    output update_ack,
    output seg,
    output digit_en,
    output digit_idx
  );
endinterface

// File: rtl/encoder_display_scanner.sv
// Scans a tear-free hex snapshot of a position value across NUM_DIGITS common-anode digits.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading-zero digits above digit 0.
module encoder_display_scanner #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 12000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  encoder_display_scanner_if.slave  bus
);

  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MaxCnt = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  if (NUM_DIGITS * 4 > DATA_W) begin : g_bad_width
    $error("NUM_DIGITS*4 must not exceed DATA_W");
  end
  if (SCAN_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
    $error("SCAN_DIV and BLANK_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]     snap_q, snap_d;
  logic                  ack_q, ack_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  lz_dark;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nyb);
    logic [6:0] g;
    case (nyb)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when idx > 0 and every nybble from idx upward is zero.
  function automatic logic lead_zero(input logic [DATA_W-1:0] snap, input logic [IdxW-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (k >= int'(idx) && snap[4*k +: 4] != 4'h0) nz = 1'b1;
    end
    return (idx != '0) && !nz;
  endfunction

  assign lz_dark = lead_zero(snap_d, idx_d);
`else
  assign lz_dark = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      // Primed so the first blank slot after reset is BLANK_CYCLES long.
      cnt_q   <= CntW'(BLANK_CYCLES - 1);
      idx_q   <= '0;
      snap_q  <= '0;
      ack_q   <= 1'b0;
      seg_q   <= 7'h7F;
      en_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ack_q   <= ack_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  // Next-state: slot timing, digit advance and frame-boundary snapshot load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ack_d   = 1'b0;
    case (state_q)
      StBlank: begin
        if (cnt_q == '0) begin
          state_d = StShow;
          cnt_d   = CntW'(SCAN_DIV - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = StBlank;
          cnt_d   = CntW'(BLANK_CYCLES - 1);
          if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            if (bus.update_req) begin
              snap_d = bus.value;
              ack_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Outputs are derived from next-state values so the pins switch on the same edge as the FSM.
  always_comb begin
    seg_d = 7'h7F;
    en_d  = '1;
    if (state_d == StShow && !lz_dark) begin
      en_d[idx_d] = 1'b0;
      seg_d       = hex_glyph(snap_d[4*idx_d +: 4]);
    end
  end

  assign bus.update_ack = ack_q;
  assign bus.seg        = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.digit_idx  = idx_q;

endmodule

// File: tb/tb_encoder_display_scanner.sv
// Directed bench for encoder_display_scanner with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_encoder_display_scanner;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  int   cyc;
  int   ack_hits;

  encoder_display_scanner_if #(.DATA_W(16), .NUM_DIGITS(4)) bus ();

  encoder_display_scanner #(
    .DATA_W      (16),
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    n_fail         = 0;
    cyc            = 0;
    rst            = 1'b1;
    bus.value      = '0;
    bus.update_req = 1'b0;

    // Reset held three cycles.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_en", 32'(bus.digit_en), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_ack", 32'(bus.update_ack), 32'h0);
    chk("rst_idx", 32'(bus.digit_idx), 32'h0);

    // Release; request a load of 0x1234 straight away.
    rst            = 1'b0;
    bus.value      = 16'h1234;
    bus.update_req = 1'b1;
    cyc            = 0;
    chk("blank0_en", 32'(bus.digit_en), 32'hF);
    tick_to(1);
    chk("blank1_en", 32'(bus.digit_en), 32'hF);
    chk("blank1_seg", 32'(bus.seg), 32'h7F);
    tick_to(2);
    chk("d0_en", 32'(bus.digit_en), 32'hE);
    chk("d0_seg_zero", 32'(bus.seg), 32'h40);
    tick_to(9);
    chk("d0_end_en", 32'(bus.digit_en), 32'hE);
    tick_to(10);
    chk("gap1_en", 32'(bus.digit_en), 32'hF);
    chk("gap1_idx", 32'(bus.digit_idx), 32'h1);
    tick_to(12);
    chk("d1_en", 32'(bus.digit_en), 32'hD);
    tick_to(20);
    chk("gap2_en", 32'(bus.digit_en), 32'hF);
    tick_to(22);
    chk("d2_en", 32'(bus.digit_en), 32'hB);
    tick_to(32);
    chk("d3_en", 32'(bus.digit_en), 32'h7);
    chk("d3_idx", 32'(bus.digit_idx), 32'h3);
    tick_to(39);
    chk("pre_ack", 32'(bus.update_ack), 32'h0);
    chk("d3_end_seg", 32'(bus.seg), 32'h40);
    tick_to(40);
    chk("ack_f1", 32'(bus.update_ack), 32'h1);
    chk("wrap_idx", 32'(bus.digit_idx), 32'h0);
    chk("wrap_en", 32'(bus.digit_en), 32'hF);
    tick_to(41);
    chk("ack_pulse", 32'(bus.update_ack), 32'h0);

    // Frame 2 shows 0x1234.
    tick_to(42);
    chk("f2_d0_seg", 32'(bus.seg), 32'h19);
    chk("f2_d0_en", 32'(bus.digit_en), 32'hE);
    tick_to(52);
    chk("f2_d1_seg", 32'(bus.seg), 32'h30);
    tick_to(62);
    chk("f2_d2_seg", 32'(bus.seg), 32'h24);
    tick_to(72);
    chk("f2_d3_seg", 32'(bus.seg), 32'h79);
    chk("f2_d3_en", 32'(bus.digit_en), 32'h7);
    tick_to(80);
    chk("ack_f2_held", 32'(bus.update_ack), 32'h1);

    // Drop the request, then wiggle value mid-frame.
    tick_to(81);
    bus.update_req = 1'b0;
    tick_to(85);
    bus.value = 16'hABCD;
    tick_to(92);
    chk("f3_d1_hold", 32'(bus.seg), 32'h30);
    tick_to(100);
    bus.value = 16'h5555;
    tick_to(120);
    chk("no_ack_f3", 32'(bus.update_ack), 32'h0);
    chk("f3_wrap_idx", 32'(bus.digit_idx), 32'h0);
    tick_to(122);
    chk("f4_d0_hold", 32'(bus.seg), 32'h19);
    tick_to(142);
    chk("f4_d2_en", 32'(bus.digit_en), 32'hB);
    chk("f4_d2_seg", 32'(bus.seg), 32'h24);

    // Reset during digit-2 SHOW with a request pending.
    tick_to(144);
    bus.update_req = 1'b1;
    rst            = 1'b1;
    tick();
    chk("mid_rst_en", 32'(bus.digit_en), 32'hF);
    chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
    chk("mid_rst_ack", 32'(bus.update_ack), 32'h0);
    chk("mid_rst_idx", 32'(bus.digit_idx), 32'h0);
    rst       = 1'b0;
    bus.value = 16'h0005;
    cyc       = 0;
    ack_hits  = 0;
    while (cyc < 40) begin
      if (bus.update_ack === 1'b1) ack_hits++;
      if (cyc == 2) chk("post_rst_d0_seg", 32'(bus.seg), 32'h40);
      tick();
    end
    chk("no_ack_rst_frame", 32'(ack_hits), 32'h0);
    chk("ack_after_rst", 32'(bus.update_ack), 32'h1);
    bus.update_req = 1'b0;

    // Snapshot 0x0005: leading-zero handling.
    tick_to(42);
    chk("lz_d0_seg", 32'(bus.seg), 32'h12);
    chk("lz_d0_en", 32'(bus.digit_en), 32'hE);
    tick_to(52);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d1_en", 32'(bus.digit_en), 32'hF);
    chk("lz_d1_seg", 32'(bus.seg), 32'h7F);
`else
    chk("lz_d1_en", 32'(bus.digit_en), 32'hD);
    chk("lz_d1_seg", 32'(bus.seg), 32'h40);
`endif
    tick_to(72);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d3_en", 32'(bus.digit_en), 32'hF);
    chk("lz_d3_seg", 32'(bus.seg), 32'h7F);
`else
    chk("lz_d3_en", 32'(bus.digit_en), 32'h7);
    chk("lz_d3_seg", 32'(bus.seg), 32'h40);
`endif
    chk("lz_d3_idx", 32'(bus.digit_idx), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
